multi_ch_accumulator: RTL and testbench

MULTI_CH_ACCUMULATOR -- requirements
Module: multi_ch_accumulator

---
 rtl/accum_pkg.sv | 25 ++
 rtl/sat_adder.sv | 33 +++
 rtl/multi_ch_accumulator.sv | 173 +++++++++++++++++
 tb/tb_multi_ch_accumulator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared helpers for the multi-channel accumulator: index widths and the
// two's-complement saturation limits for an arbitrary accumulator width.
package accum_pkg;

    localparam int SAT_MAX_W = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return idx_width(num_ch);
    endfunction

    // Largest positive value {0,1..1} of a width-bit signed number, zero-extended.
    function automatic logic [SAT_MAX_W-1:0] sat_hi(input int width);
        return (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
    endfunction

    // Most negative value {1,0..0} of a width-bit signed number, zero-extended.
    function automatic logic [SAT_MAX_W-1:0] sat_lo(input int width);
        return SAT_MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational two's-complement adder; clamps on overflow when ACCUM_SAT_EN
// is defined, otherwise wraps and never raises o_sat.
module sat_adder
    import accum_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_sat
);

    logic [WIDTH-1:0] w_raw;

    assign w_raw = i_a + i_b;

`ifdef ACCUM_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_hi(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_lo(WIDTH));

    logic w_ovf;

    // Overflow only possible when operands share a sign and the result flips it.
    assign w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_raw[WIDTH-1] != i_a[WIDTH-1]);
    assign o_sum = !w_ovf ? w_raw : (i_a[WIDTH-1] ? SAT_LO : SAT_HI);
    assign o_sat = w_ovf;
`else
    assign o_sum = w_raw;
    assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/multi_ch_accumulator.sv
// Multi-channel integrate-and-dump accumulator with a valid/ready result port.
// Define ACCUM_SAT_EN for saturating sums and sticky out_sat; default wraps.
module multi_ch_accumulator
    import accum_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int DATA_SZ  = 16,
    parameter  int ACCUM_SZ = 32,
    parameter  int DUMP_LEN = 8,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [DATA_SZ-1:0]  data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [ACCUM_SZ-1:0] accum_out,
    output logic                out_sat,
    output logic                ch_err
);

    localparam int              CNT_W    = idx_width(DUMP_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DUMP_LEN - 1);

    logic [ACCUM_SZ-1:0] r_acc [NUM_CH];
    logic [CNT_W-1:0]    r_cnt [NUM_CH];

    logic                r_out_valid;
    logic [ACCUM_SZ-1:0] r_accum_out;
    logic [CH_W-1:0]     r_out_ch;
    logic                r_out_sat;
    logic                r_ch_err;

    logic                w_accept;
    logic                w_ch_ok;
    logic                w_last;
    logic                w_dump;
    logic                w_dump_sat;
    logic                w_sat_evt;
    logic [CNT_W-1:0]    w_sel_cnt;
    logic [ACCUM_SZ-1:0] w_sel_acc;
    logic [ACCUM_SZ-1:0] w_data_ext;
    logic [ACCUM_SZ-1:0] w_sum;

    assign in_ready = !clear && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Channel select; w_ch_ok is low for codes beyond NUM_CH-1.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        w_ch_ok   = 1'b0;
        w_sel_acc = '0;
        w_sel_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                w_ch_ok   = 1'b1;
                w_sel_acc = r_acc[i];
                w_sel_cnt = r_cnt[i];
            end
        end
    end

    assign w_data_ext = {{(ACCUM_SZ - DATA_SZ){data_in[DATA_SZ-1]}}, data_in};
    assign w_last     = (w_sel_cnt == LAST_CNT);
    assign w_dump     = w_accept && w_ch_ok && w_last;

    sat_adder #(
        .WIDTH (ACCUM_SZ)
    ) u_sat_adder (
        .i_a   (w_sel_acc),
        .i_b   (w_data_ext),
        .o_sum (w_sum),
        .o_sat (w_sat_evt)
    );

    // NOTE: the per-channel arrays are plain flops rather than a RAM, which is what lets reset and clear wipe every channel in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments in clocked blocks, so every flop samples the pre-edge values of the others.
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (w_accept && w_ch_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_ch == CH_W'(i)) begin
                    if (w_last) begin
                        r_acc[i] <= '0;
                        r_cnt[i] <= '0;
                    end else begin
                        r_acc[i] <= w_sum;
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef ACCUM_SAT_EN
    logic r_sticky [NUM_CH];
    logic w_sel_sticky;

    always_comb begin
        w_sel_sticky = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                w_sel_sticky = r_sticky[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sticky[i] <= 1'b0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sticky[i] <= 1'b0;
            end
        end else if (w_accept && w_ch_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_ch == CH_W'(i)) begin
                    r_sticky[i] <= w_last ? 1'b0 : (r_sticky[i] | w_sat_evt);
                end
            end
        end
    end

    assign w_dump_sat = w_sel_sticky | w_sat_evt;
`else
    // The wrapping adder never flags, so this is a constant 0.
    assign w_dump_sat = w_sat_evt;
`endif

    // Result register: a new dump may reload in the same cycle the old one leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_accum_out <= '0;
            r_out_ch    <= '0;
            r_out_sat   <= 1'b0;
            r_ch_err    <= 1'b0;
        end else begin
            r_ch_err <= w_accept && !w_ch_ok;
            if (w_dump) begin
                r_out_valid <= 1'b1;
                r_accum_out <= w_sum;
                r_out_ch    <= in_ch;
                r_out_sat   <= w_dump_sat;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign accum_out = r_accum_out;
    assign out_ch    = r_out_ch;
    assign out_sat   = r_out_sat;
    assign ch_err    = r_ch_err;

endmodule

// File: tb/tb_multi_ch_accumulator.sv
// Bench for multi_ch_accumulator: three configurations driven in lockstep,
// each compared every cycle against an arithmetic reference model.
module tb_multi_ch_accumulator;

    localparam int ND    = 3;
    localparam int A_NCH = 4, A_AW = 32, A_DL = 8;
    localparam int B_NCH = 5, B_AW = 16, B_DL = 8;
    localparam int C_NCH = 2, C_AW = 20, C_DL = 1;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, out_ready;
    logic [2:0]  in_ch;
    logic [15:0] data_in;
    logic [2:0]  rdy, ov, sat, err;
    logic [1:0]  a_och;
    logic [2:0]  b_och;
    logic [0:0]  c_och;
    logic [31:0] a_acc;
    logic [15:0] b_acc;
    logic [19:0] c_acc;

    int n_vec = 0;
    int n_bad = 0;

    longint m_acc  [ND][8];
    int     m_cnt  [ND][8];
    bit     m_stk  [ND][8];
    bit     m_ov   [ND];
    longint m_oacc [ND];
    int     m_och  [ND];
    bit     m_osat [ND];
    bit     m_err  [ND];

    always #5 clk = ~clk;

    multi_ch_accumulator #(.NUM_CH(A_NCH), .DATA_SZ(16), .ACCUM_SZ(A_AW), .DUMP_LEN(A_DL)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_ch(in_ch[1:0]), .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready),
        .out_ch(a_och), .accum_out(a_acc), .out_sat(sat[0]), .ch_err(err[0])
    );

    multi_ch_accumulator #(.NUM_CH(B_NCH), .DATA_SZ(16), .ACCUM_SZ(B_AW), .DUMP_LEN(B_DL)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_ch(in_ch), .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready),
        .out_ch(b_och), .accum_out(b_acc), .out_sat(sat[1]), .ch_err(err[1])
    );

    multi_ch_accumulator #(.NUM_CH(C_NCH), .DATA_SZ(16), .ACCUM_SZ(C_AW), .DUMP_LEN(C_DL)) dut_c (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_ch(in_ch[0:0]), .data_in(data_in), .out_valid(ov[2]), .out_ready(out_ready),
        .out_ch(c_och), .accum_out(c_acc), .out_sat(sat[2]), .ch_err(err[2])
    );

    function automatic int nch(input int d);
        case (d) 0: return A_NCH; 1: return B_NCH; default: return C_NCH; endcase
    endfunction
    function automatic int aw(input int d);
        case (d) 0: return A_AW; 1: return B_AW; default: return C_AW; endcase
    endfunction
    function automatic int dl(input int d);
        case (d) 0: return A_DL; 1: return B_DL; default: return C_DL; endcase
    endfunction
    function automatic int chw(input int d);
        case (d) 0: return 2; 1: return 3; default: return 1; endcase
    endfunction
    function automatic logic [63:0] dut_acc(input int d);
        case (d) 0: return 64'(a_acc); 1: return 64'(b_acc); default: return 64'(c_acc); endcase
    endfunction
    function automatic logic [63:0] dut_och(input int d);
        case (d) 0: return 64'(a_och); 1: return 64'(b_och); default: return 64'(c_och); endcase
    endfunction

    function automatic logic [63:0] to_bits(input longint v, input int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint wrap_to(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= (m >> 1)) r = r - m;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_zero(input int d);
        for (int c = 0; c < 8; c++) begin
            m_acc[d][c] = 0;
            m_cnt[d][c] = 0;
            m_stk[d][c] = 1'b0;
        end
        m_ov[d]   = 1'b0;
        m_oacc[d] = 0;
        m_och[d]  = 0;
        m_osat[d] = 1'b0;
        m_err[d]  = 1'b0;
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            bit     r;
            bit     nerr;
            bit     evt;
            int     ch;
            longint s;
            longint hi;
            longint lo;
            if (reset) begin
                model_zero(d);
                continue;
            end
            r    = !clear && (!m_ov[d] || out_ready);
            nerr = 1'b0;
            if (m_ov[d] && out_ready) m_ov[d] = 1'b0;
            if (clear) begin
                for (int c = 0; c < 8; c++) begin
                    m_acc[d][c] = 0;
                    m_cnt[d][c] = 0;
                    m_stk[d][c] = 1'b0;
                end
            end else if (in_valid && r) begin
                ch = int'(in_ch) % (1 << chw(d));
                if (ch >= nch(d)) begin
                    nerr = 1'b1;
                end else begin
                    s   = m_acc[d][ch] + longint'($signed(data_in));
                    evt = 1'b0;
                    hi  = (longint'(1) << (aw(d) - 1)) - 1;
                    lo  = -hi - 1;
`ifdef ACCUM_SAT_EN
                    if (s > hi) begin
                        s = hi; evt = 1'b1;
                    end else if (s < lo) begin
                        s = lo; evt = 1'b1;
                    end
`else
                    if (s > hi || s < lo) s = wrap_to(s, aw(d));
`endif
                    if (m_cnt[d][ch] == dl(d) - 1) begin
                        m_ov[d]      = 1'b1;
                        m_oacc[d]    = s;
                        m_och[d]     = ch;
                        m_osat[d]    = m_stk[d][ch] | evt;
                        m_acc[d][ch] = 0;
                        m_cnt[d][ch] = 0;
                        m_stk[d][ch] = 1'b0;
                    end else begin
                        m_acc[d][ch] = s;
                        m_cnt[d][ch] = m_cnt[d][ch] + 1;
                        m_stk[d][ch] = m_stk[d][ch] | evt;
                    end
                end
            end
            m_err[d] = nerr;
        end
    endtask

    task automatic check_regs(input int d);
        check($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(m_ov[d]));
        if (m_ov[d]) begin
            check($sformatf("accum_out[%0d]", d), dut_acc(d), to_bits(m_oacc[d], aw(d)));
            check($sformatf("out_ch[%0d]", d), dut_och(d), 64'(m_och[d]));
            check($sformatf("out_sat[%0d]", d), 64'(sat[d]), 64'(m_osat[d]));
        end
        check($sformatf("ch_err[%0d]", d), 64'(err[d]), 64'(m_err[d]));
    endtask

    // One clock: check in_ready, step the model, then check registered outputs.
    task automatic tick();
        #1;
        for (int d = 0; d < ND; d++)
            check($sformatf("in_ready[%0d]", d), 64'(rdy[d]), 64'(!clear && (!m_ov[d] || out_ready)));
        model_edge();
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) check_regs(d);
    endtask

    task automatic send(input int ch, input logic [15:0] v);
        in_valid = 1'b1;
        in_ch    = 3'(ch);
        data_in  = v;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            model_zero(d);
            check($sformatf("rst_in_ready[%0d]", d), 64'(rdy[d]), 64'(!clear));
            check($sformatf("rst_out_valid[%0d]", d), 64'(ov[d]), 64'd0);
            check($sformatf("rst_accum_out[%0d]", d), dut_acc(d), 64'd0);
            check($sformatf("rst_out_ch[%0d]", d), dut_och(d), 64'd0);
            check($sformatf("rst_out_sat[%0d]", d), 64'(sat[d]), 64'd0);
            check($sformatf("rst_ch_err[%0d]", d), 64'(err[d]), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ch = '0; data_in = '0;
        apply_reset();

        // Eight samples of 100 on ch0 dump 800 one cycle after the last.
        for (int k = 0; k < 8; k++) begin
            send(0, 16'd100);
            if (k == 6) check("d100_early", 64'(ov[0]), 64'd0);
        end
        check("d100_valid", 64'(ov[0]), 64'd1);
        check("d100_acc", dut_acc(0), 64'd800);
        check("d100_ch", dut_och(0), 64'd0);
        check("d100_sat", 64'(sat[0]), 64'd0);

        // Positive overflow on ch1 of the 16-bit accumulator.
        for (int k = 0; k < 8; k++) send(1, 16'h7FFF);
        check("ovf_valid", 64'(ov[1]), 64'd1);
        check("ovf_ch", dut_och(1), 64'd1);
`ifdef ACCUM_SAT_EN
        check("ovf_acc", dut_acc(1), 64'h7FFF);
        check("ovf_sat", 64'(sat[1]), 64'd1);
`else
        check("ovf_acc", dut_acc(1), 64'hFFF8);
        check("ovf_sat", 64'(sat[1]), 64'd0);
`endif
        check("wide_acc", dut_acc(0), 64'h3FFF8);

        // Interleaved ch2 (-5) and ch3 (+7): ch2 completes first.
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) send(2, 16'hFFFB);
            else            send(3, 16'd7);
            if (k == 14) begin
                check("ilv_ch2", dut_och(0), 64'd2);
                check("ilv_acc2", dut_acc(0), 64'hFFFF_FFD8);
            end
            if (k == 15) begin
                check("ilv_ch3", dut_och(0), 64'd3);
                check("ilv_acc3", dut_acc(0), 64'd56);
                check("ilv_valid3", 64'(ov[0]), 64'd1);
            end
        end
        idle(1);

        // Back-pressure: pending dump stalls input until out_ready.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(0, 16'd3);
        check("bp_acc", dut_acc(0), 64'd24);
        in_valid = 1'b1; in_ch = 3'd0; data_in = 16'd50;
        #1;
        check("bp_stall_rdy", 64'(rdy[0]), 64'd0);
        repeat (3) tick();
        check("bp_hold_valid", 64'(ov[0]), 64'd1);
        check("bp_hold_acc", dut_acc(0), 64'd24);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(rdy[0]), 64'd1);
        tick();
        check("bp_drained", 64'(ov[0]), 64'd0);

        // Clear part-way through a window, then a fresh window of ones.
        for (int k = 0; k < 4; k++) send(0, 16'd9);
        clear = 1'b1; in_valid = 1'b1; data_in = 16'd9;
        #1;
        check("clr_rdy", 64'(rdy[0]), 64'd0);
        tick();
        clear = 1'b0;
        for (int k = 0; k < 8; k++) send(0, 16'd1);
        check("clr_acc", dut_acc(0), 64'd8);
        check("clr_valid", 64'(ov[0]), 64'd1);

        // Out-of-range channel on the five-channel instance.
        send(5, 16'd123);
        check("err_pulse", 64'(err[1]), 64'd1);
        idle(1);
        check("err_drop", 64'(err[1]), 64'd0);

        // Reset mid-window, then reset with a result pending.
        for (int k = 0; k < 3; k++) send(0, 16'd4);
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(0, 16'd2);
        check("rst_pend_valid", 64'(ov[0]), 64'd1);
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) send(0, 16'd2);
        check("rst_fresh_acc", dut_acc(0), 64'd16);
        check("rst_fresh_valid", 64'(ov[0]), 64'd1);

        // Randomised traffic with occasional clear and reset.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 399) == 0) apply_reset();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       data_in = 16'h7FFF - 16'($urandom_range(0, 15));
                1:       data_in = 16'h8000 + 16'($urandom_range(0, 15));
                default: data_in = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
